// File: rtl/average_scheduler.sv
// -----------------------------------------------------------------------------
// average_scheduler
//
// Shares one external 3-stage averaging pipeline (a+b | +c | *1/3, signed Q6.8)
// between NREQ requesters. At most one operand triple is issued per clock. Each
// issued triple is tagged with its requester index and tracked through the
// averager latency. The returning average is handed back with a one-cycle strobe.
// The averager has no stall input, so the result side never backpressures.
//
// Optional build macro:
//   AVG_SCHED_PRIO_EN  defined   -> fixed priority, lowest index wins (no pointer)
//                      undefined -> round-robin (default)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   sched_en   1 = grant new work, 0 = stop granting and drain
//   req        per-requester "triple valid", held until granted
//   req_a/b/c  packed operands, requester i at [i*W +: W]
//   gnt        one-hot grant (combinational), triple accepted on this edge
//   op_a/b/c   registered operands driven to the averager
//   avg_in     averager result
//   res_valid  result strobe
//   res_tag    requester index owning the result
//   res_avg    average (avg_in while res_valid, else 0)
//   busy       any triple in flight
//   state      00 IDLE, 01 RUN, 10 DRAIN
// -----------------------------------------------------------------------------
module average_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 14,
  parameter int LAT  = 3,
  parameter int TAGW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sched_en,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*W-1:0] req_c,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      op_a,
  output logic [W-1:0]      op_b,
  output logic [W-1:0]      op_c,
  input  logic [W-1:0]      avg_in,
  output logic              res_valid,
  output logic [TAGW-1:0]   res_tag,
  output logic [W-1:0]      res_avg,
  output logic              busy,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } state_t;

  state_t          r_state;
  logic [LAT:0]    r_vld;
  logic [TAGW-1:0] r_tag [LAT+1];
  logic [W-1:0]    r_op_a;
  logic [W-1:0]    r_op_b;
  logic [W-1:0]    r_op_c;

  logic            w_grant_en;
  logic            w_found;
  logic            w_take;
  logic [TAGW-1:0] w_win;
  logic [W-1:0]    w_a [NREQ];
  logic [W-1:0]    w_b [NREQ];
  logic [W-1:0]    w_c [NREQ];
  logic [W-1:0]    w_sel_a;
  logic [W-1:0]    w_sel_b;
  logic [W-1:0]    w_sel_c;

  // Unpack the operand buses so the winner can be selected without variable
  // part-selects.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_a[gi] = req_a[gi*W +: W];
      assign w_b[gi] = req_b[gi*W +: W];
      assign w_c[gi] = req_c[gi*W +: W];
    end
  endgenerate

  // Granting is allowed in RUN, and also in DRAIN the moment sched_en returns,
  // so work resumes in the same cycle the enable comes back.
  assign w_grant_en = sched_en && (r_state != ST_IDLE);

`ifdef AVG_SCHED_PRIO_EN
  // Fixed priority: scan from the top so the lowest requesting index is last
  // to write and therefore wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        w_found = 1'b1;
        w_win   = TAGW'(k);
      end
    end
  end
`else
  logic [TAGW-1:0] r_ptr;
  logic [TAGW-1:0] w_cand [NREQ];
  logic [NREQ-1:0] w_rot;

  // w_cand[k] = (r_ptr + k) mod NREQ; r_ptr < NREQ so one subtraction suffices.
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rr
      assign w_cand[gi] = (int'(r_ptr) + gi >= NREQ) ? TAGW'(int'(r_ptr) + gi - NREQ)
                                                     : TAGW'(int'(r_ptr) + gi);
      assign w_rot[gi]  = |(req & (NREQ'(1) << w_cand[gi]));
    end
  endgenerate

  // First requester at or after the pointer, in circular order.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_win   = w_cand[k];
      end
    end
  end
`endif

  assign w_take = w_grant_en && w_found;

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_gnt
      assign gnt[gi] = w_take && (w_win == TAGW'(gi));
    end
  endgenerate

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    w_sel_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == TAGW'(i)) begin
        w_sel_a = w_a[i];
        w_sel_b = w_b[i];
        w_sel_c = w_c[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_vld   <= '0;
      for (int s = 0; s <= LAT; s++) r_tag[s] <= '0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_op_c  <= '0;
`ifndef AVG_SCHED_PRIO_EN
      r_ptr   <= '0;
`endif
    end else begin
      // Valid/tag pipeline mirrors the averager latency; stage LAT lines up
      // with avg_in.
      r_vld    <= {r_vld[LAT-1:0], w_take};
      r_tag[0] <= w_take ? w_win : '0;
      for (int s = 1; s <= LAT; s++) r_tag[s] <= r_tag[s-1];

      // Idle cycles leave the operands unchanged.
      if (w_take) begin
        r_op_a <= w_sel_a;
        r_op_b <= w_sel_b;
        r_op_c <= w_sel_c;
      end

`ifndef AVG_SCHED_PRIO_EN
      if (w_take) r_ptr <= (w_win == TAGW'(NREQ - 1)) ? '0 : w_win + 1'b1;
`endif

      case (r_state)
        ST_IDLE:  if (sched_en) r_state <= ST_RUN;
        ST_RUN:   if (!sched_en) r_state <= ST_DRAIN;
        ST_DRAIN: begin
          if (sched_en)    r_state <= ST_RUN;
          else if (!busy)  r_state <= ST_IDLE;
        end
        default:           r_state <= ST_IDLE;
      endcase
    end
  end

  assign op_a      = r_op_a;
  assign op_b      = r_op_b;
  assign op_c      = r_op_c;
  assign busy      = |r_vld;
  assign res_valid = r_vld[LAT];
  assign res_tag   = r_tag[LAT];
  assign res_avg   = r_vld[LAT] ? avg_in : '0;
  assign state     = r_state;

endmodule

// File: tb/tb_average_scheduler.sv
module tb_average_scheduler;
  localparam int NREQ = 4;
  localparam int W    = 14;
  localparam int LAT  = 3;
  localparam int TAGW = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sched_en = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ*W-1:0] req_c = '0;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      op_a, op_b, op_c;
  logic [W-1:0]      avg_in = '0;
  logic              res_valid;
  logic [TAGW-1:0]   res_tag;
  logic [W-1:0]      res_avg;
  logic              busy;
  logic [1:0]        state;

  average_scheduler #(.NREQ(NREQ), .W(W), .LAT(LAT), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .sched_en(sched_en), .req(req),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .gnt(gnt),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .avg_in(avg_in),
    .res_valid(res_valid), .res_tag(res_tag), .res_avg(res_avg),
    .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  // Behavioural averager: three registered stages, no enable.
  logic signed [W+1:0] s1 = '0, c1 = '0, s2 = '0;
  always @(posedge clk) begin
    s1     <= $signed(op_a) + $signed(op_b);
    c1     <= $signed(op_c);
    s2     <= s1 + c1;
    avg_in <= W'(s2 / 3);
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          tag;
    logic [W-1:0] avg;
    int          due;
  } res_t;
  res_t q[$];

  // Reference model: mode 0 IDLE, 1 RUN, 2 DRAIN; ptr = next preferred index;
  // last_g = edge of the most recent issue.
  int m_state = 0;
  int m_ptr   = 0;
  int last_g  = -1000;
  logic [W-1:0] e_a = '0, e_b = '0, e_c = '0;

  always @(negedge clk) begin : p_model
    int win;
    logic [NREQ-1:0] eg;
    logic eb;
    if (rst) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_op_a", op_a, 0);
      chk("rst_op_b", op_b, 0);
      chk("rst_op_c", op_c, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_tag", res_tag, 0);
      chk("rst_busy", busy, 0);
      chk("rst_state", state, 0);
      m_state = 0; m_ptr = 0; last_g = -1000;
      e_a = '0; e_b = '0; e_c = '0;
      q.delete();
    end else begin
      // In flight from the issue edge up to and including the result cycle.
      eb = (cyc >= last_g) && (cyc <= last_g + LAT);
      chk("busy", busy, eb);
      chk("state", state, m_state);
      chk("op_a", op_a, e_a);
      chk("op_b", op_b, e_b);
      chk("op_c", op_c, e_c);

      win = -1;
      if (sched_en && m_state != 0) begin
`ifdef AVG_SCHED_PRIO_EN
        for (int k = NREQ - 1; k >= 0; k--) if (req[k]) win = k;
`else
        for (int k = 0; k < NREQ; k++)
          if (win < 0 && req[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
`endif
      end
      eg = '0;
      if (win >= 0) eg[win] = 1'b1;
      chk("gnt", gnt, eg);

      if (win >= 0) begin
        int sum;
        e_a = req_a[win*W +: W];
        e_b = req_b[win*W +: W];
        e_c = req_c[win*W +: W];
        sum = int'($signed(e_a)) + int'($signed(e_b)) + int'($signed(e_c));
        q.push_back('{tag: win, avg: W'(sum / 3), due: cyc + 1 + LAT});
        last_g = cyc + 1;
        m_ptr  = (win + 1) % NREQ;
      end

      case (m_state)
        0: if (sched_en) m_state = 1;
        1: if (!sched_en) m_state = 2;
        default: begin
          if (sched_en) m_state = 1;
          else if (!eb) m_state = 0;
        end
      endcase
    end
  end

  // Result monitor: pops the scoreboard whenever the DUT strobes a result.
  always @(negedge clk) begin : p_mon
    res_t e;
    if (!rst) begin
      if (res_valid) begin
        if (q.size() == 0) begin
          chk("res_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          $display("result tag=%0d avg=%h edge=%0d", res_tag, res_avg, cyc);
          chk("res_time", cyc, e.due);
          chk("res_tag", res_tag, e.tag);
          chk("res_avg", res_avg, e.avg);
          chk("res_pass", res_avg, avg_in);
        end
      end else if (q.size() > 0 && q[0].due == cyc) begin
        chk("res_missing", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  // One clock of stimulus: requesters granted this cycle drop req; idle
  // requesters raise a fresh random triple with probability pct.
  task automatic step(input logic en, input int pct);
    logic [NREQ-1:0] g;
    @(negedge clk);
    g = gnt;
    @(posedge clk);
    #1;
    sched_en = en;
    for (int i = 0; i < NREQ; i++) begin
      if (g[i]) req[i] = 1'b0;
      if (!req[i] && int'($urandom_range(99)) < pct) begin
        req[i] = 1'b1;
        req_a[i*W +: W] = W'($urandom);
        req_b[i*W +: W] = W'($urandom);
        req_c[i*W +: W] = W'($urandom);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single requester 2: -16.0 + 16.0 + 16.0.
    sched_en = 1'b1;
    req_a[2*W +: W] = 14'h3000;
    req_b[2*W +: W] = 14'h1000;
    req_c[2*W +: W] = 14'h1000;
    req[2] = 1'b1;
    repeat (10) step(1'b1, 0);

    // All requesters continuously busy: strict rotation, no gaps.
    repeat (12) step(1'b1, 100);

    // Enable dropped with requests pending: drain, then idle, no grants.
    repeat (8) step(1'b0, 100);

    // Enable returns while draining: granting resumes immediately.
    repeat (3) step(1'b1, 100);
    step(1'b0, 100);
    repeat (4) step(1'b1, 100);

    // Reset with several triples in flight.
    repeat (4) step(1'b1, 100);
    rst = 1'b1;
    repeat (2) step(1'b1, 100);
    rst = 1'b0;
    repeat (6) step(1'b1, 100);

    // Random traffic with occasional enable drops.
    for (int n = 0; n < 400; n++)
      step(int'($urandom_range(99)) < 85, int'($urandom_range(70)));

    // Final drain.
    repeat (12) step(1'b0, 0);
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
